// File: rtl/sayeh_fetch_unit_if.sv
// ============================================================================
// Module   : sayeh_fetch_unit_if
// Purpose  : Instruction-memory read bus between the SAYEH fetch unit and
//            instruction memory.
// Signals  : mem_addr  [15:0] word address driven by the fetch unit
//            mem_rd           read strobe, level, held until accepted
//            mem_ready        memory has driven mem_data this cycle
//            mem_data  [15:0] instruction word returned by memory
// Modports : master - fetch unit side, slave - memory side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sayeh_fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [15:0] mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_ready,
    output mem_data
  );
endinterface

`default_nettype wire

// File: rtl/sayeh_fetch_unit.sv
// ============================================================================
// Module   : sayeh_fetch_unit
// Purpose  : SAYEH instruction fetch stage. Reads a 16-bit word from
//            instruction memory at the PC, then delivers either one long
//            instruction (word[15:12]==4'hF) or two short instructions
//            (high byte first), pulsing o_pc_enable once per consumed word.
// Ports    : clk, rst_n       clock, asynchronous active-low reset
//            i_pc_in[15:0]    current program counter
//            i_fetch_req      single-cycle request for the next instruction
//            i_flush          branch taken: drop buffer, abort read
//            mem (master)     instruction-memory read bus
//            o_ir_out[15:0]   instruction (short form in [15:8], [7:0]=0)
//            o_ir_valid       one-cycle pulse, o_ir_out valid
//            o_ir_long        o_ir_out holds a 16-bit instruction
//            o_pc_enable      one-cycle pulse to advance the PC
//            o_mem_err        sticky read-timeout flag
// Options  : define FETCH_TIMEOUT_EN to abort a read after TIMEOUT_CYCLES
//            cycles without mem_ready; otherwise o_mem_err is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sayeh_fetch_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               i_pc_in,
  input  logic                      i_fetch_req,
  input  logic                      i_flush,
  sayeh_fetch_unit_if.master        mem,
  output logic [15:0]               o_ir_out,
  output logic                      o_ir_valid,
  output logic                      o_ir_long,
  output logic                      o_pc_enable,
  output logic                      o_mem_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    LOW_PEND = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_mem_addr;
  logic [15:0] w_mem_addr_nxt;
  logic        r_mem_rd;
  logic [7:0]  r_lo_byte;
  logic [7:0]  w_lo_byte_nxt;
  logic [15:0] r_ir_out;
  logic [15:0] w_ir_out_nxt;
  logic        r_ir_long;
  logic        w_ir_long_nxt;
  logic        r_ir_valid;
  logic        w_ir_valid_nxt;
  logic        r_pc_enable;
  logic        w_pc_enable_nxt;
  logic        w_to_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int C_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [C_CNT_W-1:0] r_to_cnt;
  logic               r_mem_err;
  logic               w_enter_read;

  // A fresh read (from IDLE, or a flush+fetch restart) restarts the count.
  assign w_enter_read = (w_state_nxt == READ) && ((r_state != READ) || i_flush);
  // r_to_cnt counts completed READ cycles without mem_ready; the last
  // permitted one aborts the read.
  assign w_to_hit     = (r_to_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt  <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (w_enter_read) begin
        r_to_cnt <= '0;
      end else if (r_state == READ) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (i_flush) begin
        r_mem_err <= 1'b0;
      end else if ((r_state == READ) && !mem.mem_ready && w_to_hit) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign o_mem_err = r_mem_err;
`else
  logic w_unused_timeout;

  assign w_to_hit         = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign o_mem_err        = 1'b0;
`endif

  // State, buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_addr  <= 16'h0000;
      r_mem_rd    <= 1'b0;
      r_lo_byte   <= 8'h00;
      r_ir_out    <= 16'h0000;
      r_ir_long   <= 1'b0;
      r_ir_valid  <= 1'b0;
      r_pc_enable <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_rd    <= (w_state_nxt == READ);
      r_lo_byte   <= w_lo_byte_nxt;
      r_ir_out    <= w_ir_out_nxt;
      r_ir_long   <= w_ir_long_nxt;
      r_ir_valid  <= w_ir_valid_nxt;
      r_pc_enable <= w_pc_enable_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_lo_byte_nxt   = r_lo_byte;
    w_ir_out_nxt    = r_ir_out;
    w_ir_long_nxt   = r_ir_long;
    w_ir_valid_nxt  = 1'b0;
    w_pc_enable_nxt = 1'b0;

    if (i_flush) begin
      // Flush wins over everything, including a same-cycle mem_ready;
      // a simultaneous fetch_req restarts a read from the new PC.
      if (i_fetch_req) begin
        w_state_nxt    = READ;
        w_mem_addr_nxt = i_pc_in;
      end else begin
        w_state_nxt    = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (i_fetch_req) begin
            w_state_nxt    = READ;
            w_mem_addr_nxt = i_pc_in;
          end
        end
        READ: begin
          if (mem.mem_ready) begin
            w_ir_valid_nxt = 1'b1;
            if (mem.mem_data[15:12] == 4'hF) begin
              w_ir_out_nxt    = mem.mem_data;
              w_ir_long_nxt   = 1'b1;
              w_pc_enable_nxt = 1'b1;
              w_state_nxt     = IDLE;
            end else begin
              w_ir_out_nxt  = {mem.mem_data[15:8], 8'h00};
              w_ir_long_nxt = 1'b0;
              w_lo_byte_nxt = mem.mem_data[7:0];
              w_state_nxt   = LOW_PEND;
            end
          end else if (w_to_hit) begin
            w_state_nxt = IDLE;
          end
        end
        LOW_PEND: begin
          if (i_fetch_req) begin
            w_ir_out_nxt    = {r_lo_byte, 8'h00};
            w_ir_long_nxt   = 1'b0;
            w_ir_valid_nxt  = 1'b1;
            w_pc_enable_nxt = 1'b1;
            w_state_nxt     = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_rd   = r_mem_rd;
  assign o_ir_out     = r_ir_out;
  assign o_ir_valid   = r_ir_valid;
  assign o_ir_long    = r_ir_long;
  assign o_pc_enable  = r_pc_enable;

endmodule

`default_nettype wire

// File: tb/tb_sayeh_fetch_unit.sv
// ============================================================================
// Module   : tb_sayeh_fetch_unit
// Purpose  : Self-checking bench for sayeh_fetch_unit: directed vector table,
//            hand-written reset / timeout sequences, and randomized traffic
//            checked against a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sayeh_fetch_unit;

  localparam int C_TO = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_in;
  logic        fetch_req;
  logic        flush;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_long;
  logic        pc_enable;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  sayeh_fetch_unit_if bus ();

  sayeh_fetch_unit #(.TIMEOUT_CYCLES(C_TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pc_in     (pc_in),
    .i_fetch_req (fetch_req),
    .i_flush     (flush),
    .mem         (bus.master),
    .o_ir_out    (ir_out),
    .o_ir_valid  (ir_valid),
    .o_ir_long   (ir_long),
    .o_pc_enable (pc_enable),
    .o_mem_err   (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        fetch;
    logic        fl;
    logic        rdy;
    logic [15:0] data;
    logic [15:0] pc;
    logic        e_valid;
    logic [15:0] e_ir;
    logic        e_long;
    logic        e_pcen;
    logic        e_rd;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vq[$];

  // Behavioural model: an outstanding-read flag plus a queue of pending
  // short instructions waiting to be handed out.
  bit         m_reading;
  logic [15:0] m_addr;
  logic [7:0] m_shortq[$];
  int         m_waited;
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req     = 1'b0;
    flush         = 1'b0;
    pc_in         = 16'h0000;
    bus.mem_ready = 1'b0;
    bus.mem_data  = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_reading = 1'b0;
    m_addr    = 16'h0000;
    m_shortq.delete();
    m_waited  = 0;
    m_err     = 1'b0;
  endtask

  // Advance the model by one cycle using the inputs currently applied.
  task automatic model_cycle(output bit e_valid, output logic [15:0] e_ir,
                             output bit e_long, output bit e_pcen);
    e_valid = 1'b0;
    e_ir    = 16'h0000;
    e_long  = 1'b0;
    e_pcen  = 1'b0;
    if (flush) begin
      m_shortq.delete();
      m_err     = 1'b0;
      m_reading = fetch_req;
      if (fetch_req) begin
        m_addr   = pc_in;
        m_waited = 0;
      end
    end else if (m_reading) begin
      if (bus.mem_ready) begin
        m_reading = 1'b0;
        e_valid   = 1'b1;
        if (bus.mem_data[15:12] == 4'hF) begin
          e_ir   = bus.mem_data;
          e_long = 1'b1;
          e_pcen = 1'b1;
        end else begin
          e_ir = {bus.mem_data[15:8], 8'h00};
          m_shortq.push_back(bus.mem_data[7:0]);
        end
      end else begin
        m_waited++;
`ifdef FETCH_TIMEOUT_EN
        if (m_waited == C_TO) begin
          m_reading = 1'b0;
          m_err     = 1'b1;
        end
`endif
      end
    end else if (m_shortq.size() > 0) begin
      if (fetch_req) begin
        e_ir    = {m_shortq.pop_front(), 8'h00};
        e_valid = 1'b1;
        e_pcen  = 1'b1;
      end
    end else if (fetch_req) begin
      m_reading = 1'b1;
      m_addr    = pc_in;
      m_waited  = 0;
    end
  endtask

  initial begin
    bit          e_valid;
    logic [15:0] e_ir;
    bit          e_long;
    bit          e_pcen;
    int          r;

    rst_n = 1'b1;
    idle_inputs();
    #3;
    do_reset();

    // Reset state.
    chk("reset_mem_rd",    32'(bus.mem_rd),   32'h0);
    chk("reset_mem_addr",  32'(bus.mem_addr), 32'h0);
    chk("reset_ir_out",    32'(ir_out),       32'h0);
    chk("reset_ir_valid",  32'(ir_valid),     32'h0);
    chk("reset_ir_long",   32'(ir_long),      32'h0);
    chk("reset_pc_enable", 32'(pc_enable),    32'h0);
    chk("reset_mem_err",   32'(mem_err),      32'h0);

    // Directed vector table: inputs applied for one cycle, outputs checked after the edge.
    //            fetch fl  rdy  data      pc        valid e_ir      long pcen rd   addr
    vq.push_back('{1'b1,1'b0,1'b0,16'h0000,16'h0010, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0010});
    vq.push_back('{1'b0,1'b0,1'b1,16'hF123,16'h0000, 1'b1,16'hF123,1'b1,1'b1,1'b0,16'h0010});
    vq.push_back('{1'b1,1'b0,1'b0,16'h0000,16'h0020, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0020});
    vq.push_back('{1'b1,1'b0,1'b0,16'h0000,16'h0099, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0020});
    vq.push_back('{1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0020});
    vq.push_back('{1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0020});
    vq.push_back('{1'b0,1'b0,1'b1,16'h2A5B,16'h0000, 1'b1,16'h2A00,1'b0,1'b0,1'b0,16'h0020});
    vq.push_back('{1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0020});
    vq.push_back('{1'b1,1'b0,1'b0,16'h0000,16'h0077, 1'b1,16'h5B00,1'b0,1'b1,1'b0,16'h0020});
    vq.push_back('{1'b1,1'b0,1'b0,16'h0000,16'h0030, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0030});
    vq.push_back('{1'b0,1'b0,1'b1,16'h1234,16'h0000, 1'b1,16'h1200,1'b0,1'b0,1'b0,16'h0030});
    vq.push_back('{1'b1,1'b1,1'b0,16'h0000,16'h0040, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0040});
    vq.push_back('{1'b0,1'b1,1'b1,16'hF999,16'h0000, 1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0040});
    vq.push_back('{1'b0,1'b0,1'b1,16'hF888,16'h0000, 1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0040});
    vq.push_back('{1'b1,1'b0,1'b0,16'h0000,16'h0050, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0050});
    vq.push_back('{1'b0,1'b0,1'b1,16'h8877,16'h0000, 1'b1,16'h8800,1'b0,1'b0,1'b0,16'h0050});
    vq.push_back('{1'b1,1'b0,1'b0,16'h0000,16'h0000, 1'b1,16'h7700,1'b0,1'b1,1'b0,16'h0050});
    vq.push_back('{1'b1,1'b0,1'b0,16'h0000,16'h0060, 1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0060});
    vq.push_back('{1'b0,1'b0,1'b1,16'hFABC,16'h0000, 1'b1,16'hFABC,1'b1,1'b1,1'b0,16'h0060});

    for (int i = 0; i < vq.size(); i++) begin
      fetch_req     = vq[i].fetch;
      flush         = vq[i].fl;
      bus.mem_ready = vq[i].rdy;
      bus.mem_data  = vq[i].data;
      pc_in         = vq[i].pc;
      step();
      chk($sformatf("vec%0d_ir_valid", i),  32'(ir_valid),  32'(vq[i].e_valid));
      chk($sformatf("vec%0d_pc_enable", i), 32'(pc_enable), 32'(vq[i].e_pcen));
      chk($sformatf("vec%0d_mem_rd", i),    32'(bus.mem_rd), 32'(vq[i].e_rd));
      chk($sformatf("vec%0d_mem_err", i),   32'(mem_err),   32'h0);
      if (vq[i].e_valid) begin
        chk($sformatf("vec%0d_ir_out", i),  32'(ir_out),  32'(vq[i].e_ir));
        chk($sformatf("vec%0d_ir_long", i), 32'(ir_long), 32'(vq[i].e_long));
      end
      if (vq[i].e_rd) begin
        chk($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vq[i].e_addr));
      end
    end
    idle_inputs();

    // Reset in the middle of a read: outputs clear immediately, a later
    // mem_ready is ignored.
    fetch_req = 1'b1;
    pc_in     = 16'h0100;
    step();
    fetch_req = 1'b0;
    chk("midrd_mem_rd", 32'(bus.mem_rd), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_rd",    32'(bus.mem_rd),   32'h0);
    chk("async_rst_mem_addr",  32'(bus.mem_addr), 32'h0);
    chk("async_rst_ir_out",    32'(ir_out),       32'h0);
    chk("async_rst_ir_valid",  32'(ir_valid),     32'h0);
    chk("async_rst_ir_long",   32'(ir_long),      32'h0);
    chk("async_rst_pc_enable", 32'(pc_enable),    32'h0);
    step();
    rst_n         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_data  = 16'hF000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_ir_valid", 32'(ir_valid),   32'h0);
      chk("post_rst_mem_rd",   32'(bus.mem_rd), 32'h0);
    end
    idle_inputs();

    // Memory that never answers.
    do_reset();
    fetch_req = 1'b1;
    pc_in     = 16'h0200;
    step();
    fetch_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int c = 1; c < C_TO; c++) begin
      chk("to_wait_mem_rd",  32'(bus.mem_rd), 32'h1);
      chk("to_wait_mem_err", 32'(mem_err),    32'h0);
      step();
    end
    chk("to_last_mem_rd", 32'(bus.mem_rd), 32'h1);
    step();
    chk("to_mem_err",  32'(mem_err),    32'h1);
    chk("to_mem_rd",   32'(bus.mem_rd), 32'h0);
    chk("to_ir_valid", 32'(ir_valid),   32'h0);
    step();
    chk("to_err_sticky", 32'(mem_err), 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("to_flush_clears_err", 32'(mem_err), 32'h0);
`else
    for (int c = 0; c < 10; c++) begin
      chk("nto_mem_rd",  32'(bus.mem_rd), 32'h1);
      chk("nto_mem_err", 32'(mem_err),    32'h0);
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("nto_flush_mem_rd", 32'(bus.mem_rd), 32'h0);
`endif

    // Randomized traffic against the behavioural model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fetch_req     = ($urandom_range(0, 99) < 50);
      flush         = ($urandom_range(0, 99) < 5);
      bus.mem_ready = ($urandom_range(0, 99) < 40);
      r             = $urandom_range(0, 99);
      bus.mem_data  = 16'($urandom);
      if (r < 30) bus.mem_data[15:12] = 4'hF;
      else if (bus.mem_data[15:12] == 4'hF) bus.mem_data[15:12] = 4'h7;
      pc_in         = 16'($urandom);
      model_cycle(e_valid, e_ir, e_long, e_pcen);
      step();
      chk("rnd_ir_valid",  32'(ir_valid),   32'(e_valid));
      chk("rnd_pc_enable", 32'(pc_enable),  32'(e_pcen));
      chk("rnd_mem_rd",    32'(bus.mem_rd), 32'(m_reading));
      chk("rnd_mem_err",   32'(mem_err),    32'(m_err));
      if (e_valid) begin
        chk("rnd_ir_out",  32'(ir_out),  32'(e_ir));
        chk("rnd_ir_long", 32'(ir_long), 32'(e_long));
      end
      if (m_reading) begin
        chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      end
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
